data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the franken_riscv data/load-store interface; the CPU initiates, this block serves.
- Single-port word-organised RAM with per-byte write enables and a valid/ready request handshake.
- Configurable wait states, so the multicycle controller's MEMRD/MEMWR states can be exercised against non-zero memory latency.
- One outstanding request at a time; responses are returned in order.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two.
- WAIT_STATES, 1: extra cycles between accept and response, range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- addr  in  32  byte address; the word index is taken from addr[31:2].
- byte_enable  in  4  byte lanes to write; bit i selects write_data[8i+7:8i].
- write_data  in  32  store data, already lane-aligned by the CPU.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  qualified by rsp_valid; the address was out of range.
- read_data  out  32  full word; qualified by rsp_valid for loads.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, read_data=0, wait counter=0.
  - RAM contents are not cleared.
  - req_ready rises on the first clk edge after reset deasserts.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On clk with req_valid=1, the request is accepted:
    - latch req_write, word index, byte_enable, write_data;
    - compute in_range = (addr - BASE_ADDR) < DEPTH_WORDS*4;
    - go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), otherwise go to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle; at 0, go to RESP.
  - RESP: req_ready=0.
    - The memory operation is performed on the edge entering RESP.
    - rsp_valid=1 for exactly one cycle, then return to IDLE.
- Latency and throughput:
  - Request accepted on edge N gives rsp_valid high in the cycle after edge N+1+WAIT_STATES.
  - Maximum throughput is one request per WAIT_STATES+3 cycles: a new request can only be accepted in IDLE after RESP.
- Loads:
  - read_data = RAM[word] registered, valid while rsp_valid=1.
  - read_data holds its value after rsp_valid falls, until the next load response.
  - byte_enable is ignored on loads; lane extraction (lbu) is done in the CPU.
- Stores:
  - For each i with byte_enable[i]=1, RAM[word][8i+7:8i] <= write_data[8i+7:8i]; other bytes are unchanged.
  - byte_enable=0000 completes normally with no modification.
  - read_data is unchanged on store responses.
- Out of range:
  - No RAM access; the response still occurs with normal latency, with rsp_err=1.
  - read_data=0 for loads.
- addr[1:0] is ignored for word selection; no misalignment error is raised.
- Request inputs are sampled only at acceptance; changes while busy are ignored. req_valid held high through RESP is re-accepted in the following IDLE cycle.
- Reset mid-operation:
  - A pending request is abandoned and no response is issued.
  - A store whose RESP-entry edge has not occurred does not modify RAM.
- Reading uninitialised RAM returns X in simulation; the bench must preload the RAM.

Decomposition:
- Shared package franken_mem_pkg: state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), WORD_BYTES=4, BE_WORD=4'b1111.
- Sub-module byte_ram (parameter DEPTH_WORDS): synchronous single-port RAM with 4-bit byte write enable and registered read output.
- The FSM, counter and range check stay in data_mem_responder.

Test Plan:
- Reset then store, WAIT_STATES=1: reset low for 3 cycles → req_ready=0, rsp_valid=0, read_data=0 during reset; req_ready=1 one edge after release. sw addr=0x10, be=1111, data=0xDEADBEEF accepted at edge N → rsp_valid=1, rsp_err=0 after edge N+2; a following lw 0x10 returns 0xDEADBEEF.
- Byte-lane stores: word 0x10 = 0xDEADBEEF; sb addr=0x12, be=0100, data=0x00AA0000 → lw 0x10 returns 0xDEAABEEF; be=0000 store leaves it unchanged.
- Latency sweep: WAIT_STATES=0 and WAIT_STATES=3 → rsp_valid exactly 1 and 4 cycles after accept respectively; req_ready=0 from accept through RESP.
- Out of range, DEPTH_WORDS=1024: lw 0x1000 → rsp_err=1, read_data=0. sw 0x1000 → rsp_err=1 and word 0 unchanged.
- Back-to-back: req_valid held high with changing addr/data during WAIT → only the first request is served; the next is accepted in the IDLE cycle after RESP.
- Reset mid-op: sw 0x20 data=0x12345678 accepted, reset asserted during WAIT → no rsp_valid; after release, lw 0x20 returns the preloaded old value.

Source files
------------

// File: rtl/franken_mem_pkg.sv
// rtl/franken_mem_pkg.sv - shared constants and types for the data memory responder
//
// Purpose : state encoding, word geometry and the latched request record
//           used by data_mem_responder and byte_ram.
// Ports   : none (package).
package franken_mem_pkg;

    // Responder FSM encoding (kept as plain constants for legacy tools).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  BE_WORD    = 4'b1111;

    // Request fields captured at acceptance; the word index is held
    // separately because its width depends on the RAM depth.
    typedef struct packed {
        logic        write;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        in_range;
    } mem_req_t;

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - single-port word RAM with byte write enables and registered read
//
// Purpose : synchronous storage behind data_mem_responder. A write updates
//           only the lanes selected by be_i; a read (en_i && !we_i) loads
//           the addressed word into the output register. The output
//           register is left untouched by writes and idle cycles.
// Ports   : clk_i    clock, rising edge
//           en_i     access strobe for this cycle
//           we_i     1 = write, 0 = read
//           be_i     byte lanes to write
//           addr_i   word index
//           wdata_i  lane-aligned write data
//           rdata_o  registered read data
module byte_ram
    import franken_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // No reset: contents survive a responder reset by design.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - valid/ready data memory responder with wait states
//
// Purpose : serves one load/store at a time from a byte-writable RAM.
//           A request accepted on edge N performs its RAM access on the
//           edge that enters RESP (N+WAIT_STATES) and presents the
//           one-cycle response after edge N+1+WAIT_STATES; the controller
//           then spends one cycle in IDLE before it can accept again.
// Ports   : clk          clock, rising edge
//           reset        asynchronous active-low reset
//           req_valid    request present
//           req_ready    request can be accepted (registered)
//           req_write    1 = store, 0 = load
//           addr         byte address, word index from addr[31:2]
//           byte_enable  store byte lanes
//           write_data   lane-aligned store data
//           rsp_valid    one-cycle response pulse
//           rsp_err      address was out of range (with rsp_valid)
//           read_data    load data, held until the next load response
module data_mem_responder
    import franken_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] read_data
);

    localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] DEPTH_BYTES = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
    localparam logic [3:0]  WAIT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic        NO_WAIT     = (WAIT_STATES == 0);

    logic [1:0]    state_q,     state_d;
    logic          resp_ph_q,   resp_ph_d;
    logic [3:0]    cnt_q,       cnt_d;
    mem_req_t      req_q,       req_d;
    logic [AW-1:0] word_q,      word_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q,   rsp_err_d;
    logic [31:0]   read_data_q, read_data_d;

    logic [31:0]   offset;
    logic          in_range_in;
    logic [AW-1:0] word_in;
    logic          accept;
    logic          mem_go;
    logic          op_live;
    logic          op_write;
    logic          op_in_range;
    logic [3:0]    op_be;
    logic [31:0]   op_wdata;
    logic [AW-1:0] op_word;
    logic [31:0]   ram_rdata;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign offset      = addr - BASE_ADDR;
    assign in_range_in = ({1'b0, offset} < DEPTH_BYTES);
    assign word_in     = offset[AW+1:2];

    assign accept = (state_q == ST_IDLE) && req_ready_q && req_valid;

    // The RAM access happens on the edge entering RESP. With no wait
    // states that is the acceptance edge itself, so the live request
    // inputs feed the RAM instead of the not-yet-latched copy.
    assign mem_go  = (accept && NO_WAIT) || ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    assign op_live = (state_q == ST_IDLE);

    assign op_write    = op_live ? req_write   : req_q.write;
    assign op_be       = op_live ? byte_enable : req_q.be;
    assign op_wdata    = op_live ? write_data  : req_q.wdata;
    assign op_in_range = op_live ? in_range_in : req_q.in_range;
    assign op_word     = op_live ? word_in     : word_q;

    byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (mem_go && op_in_range),
        .we_i    (op_write),
        .be_i    (op_be),
        .addr_i  (op_word),
        .wdata_i (op_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        resp_ph_d   = resp_ph_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        word_d      = word_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        read_data_d = read_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d.write    = req_write;
                    req_d.be       = byte_enable;
                    req_d.wdata    = write_data;
                    req_d.in_range = in_range_in;
                    word_d         = word_in;
                    resp_ph_d      = 1'b0;
                    if (NO_WAIT) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_RESP;
                    resp_ph_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // Phase 0: RAM output register now holds the word; capture
                // it and raise the response. Phase 1: response cycle.
                if (!resp_ph_q) begin
                    resp_ph_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !req_q.in_range;
                    if (!req_q.write) begin
                        read_data_d = req_q.in_range ? ram_rdata : 32'h0;
                    end
                end else begin
                    state_d   = ST_IDLE;
                    resp_ph_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                resp_ph_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            resp_ph_q   <= 1'b0;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            word_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            resp_ph_q   <= resp_ph_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            word_q      <= word_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            read_data_q <= read_data_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [3:0]  byte_enable = 4'h0;
    logic [31:0] write_data = 32'h0;

    logic        vld0 = 1'b0, vld1 = 1'b0, vld3 = 1'b0;
    logic        rdy0, rdy1, rdy3;
    logic        rv0, rv1, rv3;
    logic        re0, re1, re3;
    logic [31:0] rd0, rd1, rd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .clk(clk), .reset(reset), .req_valid(vld0), .req_ready(rdy0), .req_write(req_write),
        .addr(addr), .byte_enable(byte_enable), .write_data(write_data),
        .rsp_valid(rv0), .rsp_err(re0), .read_data(rd0));

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
        .clk(clk), .reset(reset), .req_valid(vld1), .req_ready(rdy1), .req_write(req_write),
        .addr(addr), .byte_enable(byte_enable), .write_data(write_data),
        .rsp_valid(rv1), .rsp_err(re1), .read_data(rd1));

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
        .clk(clk), .reset(reset), .req_valid(vld3), .req_ready(rdy3), .req_write(req_write),
        .addr(addr), .byte_enable(byte_enable), .write_data(write_data),
        .rsp_valid(rv3), .rsp_err(re3), .read_data(rd3));

    function automatic logic get_ready(input int w);
        return (w == 0) ? rdy0 : (w == 1) ? rdy1 : rdy3;
    endfunction
    function automatic logic get_valid(input int w);
        return (w == 0) ? rv0 : (w == 1) ? rv1 : rv3;
    endfunction
    function automatic logic get_err(input int w);
        return (w == 0) ? re0 : (w == 1) ? re1 : re3;
    endfunction
    function automatic logic [31:0] get_rd(input int w);
        return (w == 0) ? rd0 : (w == 1) ? rd1 : rd3;
    endfunction

    task automatic set_valid(input int w, input logic v);
        case (w)
            0: vld0 = v;
            1: vld1 = v;
            default: vld3 = v;
        endcase
    endtask

    // Issues one request to instance w. lat counts edges after the accept
    // edge until rsp_valid is seen; busy is any req_ready=1 from accept to
    // the response cycle; after is rsp_valid one cycle past the response.
    task automatic do_req(input int w, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d,
                          output int lat, output logic err, output logic [31:0] rd,
                          output logic busy, output logic after);
        bit found = 0;
        lat = -1; err = 1'bx; rd = 32'hx; busy = 1'b0; after = 1'bx;
        @(negedge clk);
        req_write = wr; addr = a; byte_enable = be; write_data = d;
        set_valid(w, 1'b1);
        for (int t = 0; t < 20 && !get_ready(w); t++) @(negedge clk);
        if (!get_ready(w)) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut=%0d: req_ready never 1 within 20 cycles", w);
            set_valid(w, 1'b0);
        end else begin
            @(negedge clk);
            set_valid(w, 1'b0);
            busy = get_ready(w);
            lat = 0;
            for (int t = 0; t < 20; t++) begin
                if (get_valid(w)) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
                lat++;
                busy = busy | get_ready(w);
            end
            if (!found) begin
                checks++; errors++;
                $display("FAIL rsp_timeout dut=%0d: rsp_valid never seen within 20 cycles", w);
                lat = -1;
            end else begin
                err = get_err(w);
                rd  = get_rd(w);
                @(negedge clk);
                after = get_valid(w);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rdy1 !== 1'b0 || rv1 !== 1'b0 || rd1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: ready=%b valid=%b rdata=%h, expected 0 0 00000000", rdy1, rv1, rd1);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", rdy1);
        end
        @(negedge clk);
        checks++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b1 || rdy3 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b%b%b expected 111", rdy0, rdy1, rdy3);
        end
    endtask

    task automatic test_store_load();
        int lat; logic err; logic [31:0] rd; logic busy, after;
        do_req(1, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, lat, err, rd, busy, after);
        checks++;
        if (lat !== 2 || err !== 1'b0 || busy !== 1'b0 || after !== 1'b0) begin
            errors++;
            $display("FAIL sw_ws1: lat=%0d err=%b busy=%b after=%b expected 2 0 0 0", lat, err, busy, after);
        end
        do_req(1, 1'b0, 32'h10, 4'b0000, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL lw_ws1: rd=%h err=%b lat=%0d expected deadbeef 0 2", rd, err, lat);
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic err; logic [31:0] rd; logic busy, after;
        do_req(1, 1'b1, 32'h12, 4'b0100, 32'h00AA0000, lat, err, rd, busy, after);
        do_req(1, 1'b0, 32'h10, 4'b0000, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (rd !== 32'hDEAABEEF) begin
            errors++;
            $display("FAIL sb_lane2: rd=%h expected deaabeef", rd);
        end
        do_req(1, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, lat, err, rd, busy, after);
        checks++;
        if (err !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL be0_rsp: err=%b lat=%0d expected 0 2", err, lat);
        end
        do_req(1, 1'b0, 32'h13, 4'b1111, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (rd !== 32'hDEAABEEF) begin
            errors++;
            $display("FAIL be0_unchanged_unaligned: rd=%h expected deaabeef", rd);
        end
    endtask

    task automatic test_latency();
        int lat; logic err; logic [31:0] rd; logic busy, after;
        do_req(0, 1'b1, 32'h40, 4'b1111, 32'h0BADF00D, lat, err, rd, busy, after);
        checks++;
        if (lat !== 1 || busy !== 1'b0 || after !== 1'b0) begin
            errors++;
            $display("FAIL lat_ws0_sw: lat=%0d busy=%b after=%b expected 1 0 0", lat, busy, after);
        end
        do_req(0, 1'b0, 32'h40, 4'b0000, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (lat !== 1 || rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL lat_ws0_lw: lat=%0d rd=%h expected 1 0badf00d", lat, rd);
        end
        do_req(2, 1'b1, 32'h40, 4'b1111, 32'h13572468, lat, err, rd, busy, after);
        checks++;
        if (lat !== 4 || busy !== 1'b0 || after !== 1'b0) begin
            errors++;
            $display("FAIL lat_ws3_sw: lat=%0d busy=%b after=%b expected 4 0 0", lat, busy, after);
        end
        do_req(2, 1'b0, 32'h40, 4'b0000, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (lat !== 4 || rd !== 32'h13572468) begin
            errors++;
            $display("FAIL lat_ws3_lw: lat=%0d rd=%h expected 4 13572468", lat, rd);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic err; logic [31:0] rd; logic busy, after;
        do_req(1, 1'b1, 32'h0, 4'b1111, 32'h11112222, lat, err, rd, busy, after);
        do_req(1, 1'b1, 32'hFFC, 4'b1111, 32'hCAFE0001, lat, err, rd, busy, after);
        do_req(1, 1'b0, 32'hFFC, 4'b0000, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (rd !== 32'hCAFE0001 || err !== 1'b0) begin
            errors++;
            $display("FAIL last_word: rd=%h err=%b expected cafe0001 0", rd, err);
        end
        do_req(1, 1'b0, 32'h1000, 4'b0000, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (rd !== 32'h0 || err !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL oor_lw: rd=%h err=%b lat=%0d expected 00000000 1 2", rd, err, lat);
        end
        do_req(1, 1'b1, 32'h1000, 4'b1111, 32'hFFFFFFFF, lat, err, rd, busy, after);
        checks++;
        if (err !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL oor_sw: err=%b lat=%0d expected 1 2", err, lat);
        end
        do_req(1, 1'b0, 32'h0, 4'b0000, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (rd !== 32'h11112222 || err !== 1'b0) begin
            errors++;
            $display("FAIL oor_word0_intact: rd=%h err=%b expected 11112222 0", rd, err);
        end
        do_req(1, 1'b1, 32'h80, 4'b1111, 32'h55555555, lat, err, rd, busy, after);
        checks++;
        if (rd1 !== 32'h11112222) begin
            errors++;
            $display("FAIL rdata_hold_after_store: rd=%h expected 11112222", rd1);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic err; logic [31:0] rd; logic busy, after;
        do_req(1, 1'b1, 32'h50, 4'b1111, 32'hAAAA0001, lat, err, rd, busy, after);
        do_req(1, 1'b1, 32'h54, 4'b1111, 32'hBBBB0002, lat, err, rd, busy, after);
        @(negedge clk);
        req_write = 1'b0; addr = 32'h50; byte_enable = 4'b0000; write_data = 32'h0;
        vld1 = 1'b1;
        checks++;
        if (rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_ready: got %b expected 1", rdy1);
        end
        @(negedge clk);                 // k=0: first request accepted
        addr = 32'h54; write_data = 32'h99999999;
        @(negedge clk);                 // k=1
        checks++;
        if (rv1 !== 1'b0 || rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_k1: valid=%b ready=%b expected 0 0", rv1, rdy1);
        end
        @(negedge clk);                 // k=2
        checks++;
        if (rv1 !== 1'b1 || rd1 !== 32'hAAAA0001 || rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_rsp: valid=%b rd=%h ready=%b expected 1 aaaa0001 0", rv1, rd1, rdy1);
        end
        @(negedge clk);                 // k=3: idle gap
        checks++;
        if (rv1 !== 1'b0 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap: valid=%b ready=%b expected 0 1", rv1, rdy1);
        end
        @(negedge clk);                 // k=4: second request accepted
        vld1 = 1'b0;
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: ready=%b expected 0", rdy1);
        end
        @(negedge clk);                 // k=5
        checks++;
        if (rv1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_k5: valid=%b expected 0", rv1);
        end
        @(negedge clk);                 // k=6
        checks++;
        if (rv1 !== 1'b1 || rd1 !== 32'hBBBB0002) begin
            errors++;
            $display("FAIL b2b_second_rsp: valid=%b rd=%h expected 1 bbbb0002", rv1, rd1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat; logic err; logic [31:0] rd; logic busy, after;
        logic seen = 1'b0;
        do_req(1, 1'b1, 32'h20, 4'b1111, 32'hCAFEBABE, lat, err, rd, busy, after);
        @(negedge clk);
        req_write = 1'b1; addr = 32'h20; byte_enable = 4'b1111; write_data = 32'h12345678;
        vld1 = 1'b1;
        @(negedge clk);                 // accepted, now in WAIT
        vld1 = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | rv1;
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | rv1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_rsp: rsp_valid seen=%b expected 0", seen);
        end
        do_req(1, 1'b0, 32'h20, 4'b0000, 32'h0, lat, err, rd, busy, after);
        checks++;
        if (rd !== 32'hCAFEBABE || err !== 1'b0) begin
            errors++;
            $display("FAIL midop_ram_intact: rd=%h err=%b expected cafebabe 0", rd, err);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_latency();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
